// File: rtl/vector_issue_buffer_pkg.sv
// vector_issue_buffer_pkg: issue FSM encoding private to the vector issue buffer.
package vector_issue_buffer_pkg;
    typedef enum logic {RUN, DRAIN} issue_state_e;
endpackage

// File: rtl/vstructs.sv
// vstructs: packet types shared between the instruction source and the vector core.
package vstructs;
    localparam int VL_W = $clog2(32 * 8) + 1;

    typedef struct packed {
        logic            valid;
        logic            reconfigure;
        logic [4:0]      op;
        logic [4:0]      dst;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [VL_W-1:0] vl;
        logic [VL_W-1:0] maxvl;
    } to_vector;
endpackage

// File: rtl/vector_issue_buffer_if.sv
// vector_issue_buffer_if: upstream valid/pop and downstream valid/ready handshakes of the issue buffer.
interface vector_issue_buffer_if;
    import vstructs::*;
    logic     valid_i;
    to_vector instr_i;
    logic     pop_o;
    logic     valid_o;
    to_vector instr_o;
    logic     ready_i;
    logic     vector_idle_i;

    modport slave (input valid_i, instr_i, ready_i, vector_idle_i, output pop_o, valid_o, instr_o);
    modport master (output valid_i, instr_i, ready_i, vector_idle_i, input pop_o, valid_o, instr_o);
endinterface

// File: rtl/vector_instr_fifo.sv
// vector_instr_fifo: circular buffer of to_vector packets; DEPTH need not be a power of two.
module vector_instr_fifo
    import vstructs::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  to_vector      data_i,
    input  logic          pop_i,
    output to_vector      data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    to_vector      mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[head_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        head_d  = do_pop ? nxt(head_q) : head_q;
        tail_d  = do_push ? nxt(tail_q) : tail_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= data_i;
    end
endmodule

// File: rtl/vector_issue_buffer.sv
// vector_issue_buffer: elastic in-order buffer to the vector core; reconfigure packets
// wait at the head until the vector core is idle, and the last issued vl/maxvl are kept.
module vector_issue_buffer
    import vstructs::*;
    import vector_issue_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int VECTOR_REGISTERS = 32,
    parameter int VECTOR_LANES = 8,
    localparam int VLW = $clog2(VECTOR_REGISTERS * VECTOR_LANES) + 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vector_issue_buffer_if.slave  issue_if,
    output logic [VLW-1:0]        cur_vl_o,
    output logic [VLW-1:0]        cur_maxvl_o,
    output logic [CW-1:0]         count_o
);
    issue_state_e   state_q, state_d;
    to_vector       head;
    logic           full, empty, valid, issue;
    logic [VLW-1:0] cur_vl_q, cur_maxvl_q;

    // Accept only on a non-full queue, independent of ready_i.
    assign issue_if.pop_o = rst_n & issue_if.valid_i & ~full;
    assign issue          = valid & issue_if.ready_i;
    assign issue_if.valid_o = valid;
    assign cur_vl_o       = cur_vl_q;
    assign cur_maxvl_o    = cur_maxvl_q;

    vector_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue_if.pop_o),
        .data_i  (issue_if.instr_i),
        .pop_i   (issue),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        issue_if.instr_o = head;
        valid   = (state_q == DRAIN) ? issue_if.vector_idle_i & ~empty : ~empty & ~head.reconfigure;
        state_d = (state_q == RUN) ? ((~empty & head.reconfigure) ? DRAIN : RUN) : (issue ? RUN : DRAIN);
        issue_if.instr_o.valid = valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cur_vl_q    <= '0;
            cur_maxvl_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue && state_q == DRAIN) begin
                cur_vl_q    <= VLW'(head.vl);
                cur_maxvl_q <= VLW'(head.maxvl);
            end
        end
    end
endmodule

// File: tb/tb_vector_issue_buffer.sv
// tb_vector_issue_buffer: directed stimulus with a scoreboard queue checked by an
// independent monitor on every downstream handshake.
module tb_vector_issue_buffer;
    import vstructs::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] cur_vl, cur_maxvl;
    logic [2:0] count;
    int         n_vec = 0;
    int         n_err = 0;
    to_vector   exp_q [$];
    to_vector   mon_e;

    vector_issue_buffer_if vif ();

    vector_issue_buffer #(.DEPTH(4), .VECTOR_REGISTERS(32), .VECTOR_LANES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_if    (vif),
        .cur_vl_o    (cur_vl),
        .cur_maxvl_o (cur_maxvl),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic to_vector alu(input int d);
        to_vector p;
        p       = '0;
        p.valid = 1'b1;
        p.op    = 5'd3;
        p.dst   = 5'(d);
        p.src1  = 5'(d + 1);
        p.src2  = 5'(d + 2);
        return p;
    endfunction

    function automatic to_vector cfg(input int vl, input int mvl);
        to_vector p;
        p             = '0;
        p.valid       = 1'b1;
        p.reconfigure = 1'b1;
        p.op          = 5'd31;
        p.vl          = 9'(vl);
        p.maxvl       = 9'(mvl);
        return p;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_push();
        if (vif.pop_o) exp_q.push_back(vif.instr_i);
    endtask

    task automatic drain(input string name);
        int k = 0;
        vif.valid_i = 1'b0;
        vif.ready_i = 1'b1;
        vif.vector_idle_i = 1'b1;
        while (count != 0 && k < 20) begin
            next();
            k++;
        end
        check(name, 64'(count), 64'(0));
    endtask

    // Scoreboard monitor: every accepted downstream packet must match the oldest pushed one.
    always @(negedge clk) begin
        if (rst_n && vif.valid_o && vif.ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_issue: got %0h, expected no packet", vif.instr_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_order", 64'(vif.instr_o), 64'(mon_e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sent;
        int cyc;
        vif.valid_i = 1'b1;
        vif.instr_i = alu(9);
        vif.ready_i = 1'b0;
        vif.vector_idle_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pop", 64'(vif.pop_o), 64'(0));
        check("rst_valid", 64'(vif.valid_o), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_vl", 64'(cur_vl), 64'(0));
        check("rst_maxvl", 64'(cur_maxvl), 64'(0));
        vif.valid_i = 1'b0;
        next();
        rst_n = 1'b1;

        // Stream of 4 ALU packets with ready high.
        vif.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vif.valid_i = (i < 4);
            vif.instr_i = alu(i + 1);
            @(negedge clk);
            check("t1_pop", 64'(vif.pop_o), 64'(i < 4));
            check("t1_valid", 64'(vif.valid_o), 64'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) check("t1_dst", 64'(vif.instr_o.dst), 64'(i));
            sample_push();
            next();
        end

        // Fill to DEPTH with ready low, then free one slot.
        vif.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vif.valid_i = 1'b1;
            vif.instr_i = alu(11 + i);
            @(negedge clk);
            check("t2_fill_pop", 64'(vif.pop_o), 64'(1));
            sample_push();
            next();
        end
        vif.instr_i = alu(15);
        @(negedge clk);
        check("t2_full_pop", 64'(vif.pop_o), 64'(0));
        check("t2_full_count", 64'(count), 64'(4));
        next();
        vif.ready_i = 1'b1;
        @(negedge clk);
        check("t2_full_issue_pop", 64'(vif.pop_o), 64'(0));
        check("t2_full_issue_valid", 64'(vif.valid_o), 64'(1));
        check("t2_full_issue_dst", 64'(vif.instr_o.dst), 64'(11));
        next();
        vif.ready_i = 1'b0;
        @(negedge clk);
        check("t2_refill_pop", 64'(vif.pop_o), 64'(1));
        check("t2_refill_count", 64'(count), 64'(3));
        sample_push();
        next();
        drain("t2_drain");

        // Reconfigure behind two ALU packets while the core is busy.
        vif.ready_i = 1'b1;
        vif.vector_idle_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vif.valid_i = 1'b1;
            vif.instr_i = (i == 2) ? cfg(17, 64) : alu(21 + i);
            @(negedge clk);
            check("t3_pop", 64'(vif.pop_o), 64'(1));
            if (i >= 1) check("t3_alu_valid", 64'(vif.valid_o), 64'(1));
            sample_push();
            next();
        end
        vif.valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(vif.valid_o), 64'(0));
            check("t3_hold_count", 64'(count), 64'(1));
            next();
        end
        vif.vector_idle_i = 1'b1;
        @(negedge clk);
        check("t3_cfg_valid", 64'(vif.valid_o), 64'(1));
        check("t3_cfg_flag", 64'(vif.instr_o.reconfigure), 64'(1));
        next();
        @(negedge clk);
        check("t3_vl", 64'(cur_vl), 64'(17));
        check("t3_maxvl", 64'(cur_maxvl), 64'(64));
        check("t3_count", 64'(count), 64'(0));
        check("t3_valid_after", 64'(vif.valid_o), 64'(0));
        next();

        // Wrap-around with ready toggling each cycle.
        sent = 0;
        cyc = 0;
        while ((sent < 10 || count != 0) && cyc < 60) begin
            vif.ready_i = (cyc % 2 == 0);
            vif.valid_i = (sent < 10);
            vif.instr_i = alu(16 + sent);
            @(negedge clk);
            check("t4_count_bound", 64'(count <= 4), 64'(1));
            sample_push();
            if (vif.pop_o) sent++;
            next();
            cyc++;
        end
        check("t4_sent", 64'(sent), 64'(10));
        check("t4_empty", 64'(count), 64'(0));
        check("t4_scoreboard_empty", 64'(exp_q.size()), 64'(0));

        // Idle drops during DRAIN with ready low.
        vif.ready_i = 1'b0;
        vif.vector_idle_i = 1'b1;
        vif.valid_i = 1'b1;
        vif.instr_i = cfg(5, 8);
        @(negedge clk);
        check("t5_pop", 64'(vif.pop_o), 64'(1));
        sample_push();
        next();
        vif.valid_i = 1'b0;
        @(negedge clk);
        check("t5_run_valid", 64'(vif.valid_o), 64'(0));
        next();
        @(negedge clk);
        check("t5_drain_valid", 64'(vif.valid_o), 64'(1));
        next();
        vif.vector_idle_i = 1'b0;
        @(negedge clk);
        check("t5_idle_drop_valid", 64'(vif.valid_o), 64'(0));
        check("t5_idle_drop_count", 64'(count), 64'(1));
        next();
        vif.vector_idle_i = 1'b1;
        vif.ready_i = 1'b1;
        @(negedge clk);
        check("t5_reissue_valid", 64'(vif.valid_o), 64'(1));
        check("t5_vl_before", 64'(cur_vl), 64'(17));
        next();
        @(negedge clk);
        check("t5_vl", 64'(cur_vl), 64'(5));
        check("t5_maxvl", 64'(cur_maxvl), 64'(8));
        check("t5_count", 64'(count), 64'(0));
        next();

        // Asynchronous reset with three entries and the FSM in DRAIN.
        vif.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vif.valid_i = 1'b1;
            vif.instr_i = (i == 0) ? cfg(9, 16) : alu(i + 1);
            @(negedge clk);
            check("t6_pop", 64'(vif.pop_o), 64'(1));
            sample_push();
            next();
        end
        vif.valid_i = 1'b0;
        @(negedge clk);
        check("t6_pre_count", 64'(count), 64'(3));
        check("t6_pre_valid", 64'(vif.valid_o), 64'(1));
        #2;
        vif.valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(vif.valid_o), 64'(0));
        check("t6_rst_count", 64'(count), 64'(0));
        check("t6_rst_vl", 64'(cur_vl), 64'(0));
        check("t6_rst_maxvl", 64'(cur_maxvl), 64'(0));
        check("t6_rst_pop", 64'(vif.pop_o), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        vif.valid_i = 1'b0;
        rst_n = 1'b1;
        vif.vector_idle_i = 1'b0;
        vif.ready_i = 1'b1;
        vif.valid_i = 1'b1;
        vif.instr_i = alu(7);
        @(negedge clk);
        check("t6_post_pop", 64'(vif.pop_o), 64'(1));
        sample_push();
        next();
        vif.valid_i = 1'b0;
        @(negedge clk);
        check("t6_post_run_valid", 64'(vif.valid_o), 64'(1));
        check("t6_post_dst", 64'(vif.instr_o.dst), 64'(7));
        next();
        @(negedge clk);
        check("t6_post_count", 64'(count), 64'(0));
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
